serial_addsub_hex: RTL and testbench
====================================

# serial_addsub_hex

Parametrised bit-serial adder/subtractor with a multiplexed hexadecimal seven-segment display, for the lab board switch/LED datapath. Two WIDTH-bit switch operands are captured on a start pulse and added or subtracted one bit per clock, LSB first. The registered result, carry-out and signed overflow are then held. The result is continuously scanned across WIDTH/4 common-anode digits.

## Interface
- WIDTH, 8: operand/result width; multiple of 4, range 4..32; NDIG = WIDTH/4.
- REFRESH, 1000: clocks each digit stays selected during display scan; minimum 1.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sw1  in  WIDTH  operand A.
- sw2  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode).
- sub  in  1  0 = A+B+cin; 1 = A-B (cin ignored).
- start  in  1  request; sampled only in IDLE.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when result registers update.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  registered signed overflow.
- digit_sel  out  NDIG  one-cold digit enable, bit i drives digit i (nibble i of sum).
- led  out  7  active-low segments, led[6:0] = g,f,e,d,c,b,a.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: on rising edge with start=1, load A = sw1, B = sub ? ~sw2 : sw2, carry = sub ? 1 : cin, bit counter = 0, go RUN. start=0: stay.
- RUN: each edge computes s = A[0]^B[0]^carry and carry' = majority(A[0],B[0],carry). s is shifted into the result shift register from the MSB side, A and B shift right, and the counter increments.
- RUN exit: the edge processing bit WIDTH-1 goes to DONE. On that same edge, sum <= full shifted result, cout <= final carry, and ovf <= (carry into MSB) ^ (carry out of MSB).
- DONE: lasts exactly one cycle, then IDLE.
- start is ignored in RUN and DONE; there is no queuing. sw1/sw2/sub/cin changes after capture have no effect on the operation in flight.
- sum/cout/ovf hold their values until the next DONE entry.
- Display: the scan counter counts 0..REFRESH-1. On wrap, the digit index advances 0..NDIG-1 and wraps to 0. digit_sel has a 0 only at the current index. led = hex glyph of sum[4*idx+3:4*idx].
- Glyphs 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Display scan runs independently of adder state and never stalls.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, scan counter 0, digit index 0, digit_sel = all ones except bit 0, led = 1000000.
- Reset asserted mid-RUN aborts immediately to the reset values; no done pulse.
- start sampled high at edge k: busy = 1 from after edge k through after edge k+WIDTH-1 (WIDTH cycles).
- done = 1 and new sum valid after edge k+WIDTH, for one cycle; busy = 0 in that cycle.
- Earliest next accepted start is the edge at k+WIDTH+1; latency start-to-done = WIDTH+1 edges.
- busy and done are registered (state decode), never both high.
- led/digit_sel are registered and update on the same edge as the digit index advance. A sum change shows on the current digit on the next edge.

## Test plan
- WIDTH=8, add sw1=0x3A, sw2=0x45, cin=0, start at edge k -> busy high 8 cycles, done after edge k+8, sum=0x7F, cout=0, ovf=0.
- Add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. Add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Add 0x00+0x00 with cin=1 -> sum=0x01.
- Sub: sw1=0x10, sw2=0x20, cin=1 -> sum=0xF0, cout=0, ovf=0. Sub: sw1=0x80, sw2=0x01 -> sum=0x7F, cout=1, ovf=1.
- start re-pulsed during RUN and in the DONE cycle, with sw1 changed -> ignored; exactly one done; result is from the original operands.
- rst_n low at bit 3 of a RUN -> all outputs at reset values immediately. After release, a new start gives the correct result with no stale done.
- REFRESH=4, sum=0xA5 -> digit_sel alternates 10 / 01 every 4 cycles. led = 0010010 while digit 0 is selected, 0001000 while digit 1 is selected. Index wraps 1 -> 0.

Source files
------------

// File: rtl/serial_addsub_hex.sv
// serial_addsub_hex: bit-serial adder/subtractor (LSB first) whose held result
// is scanned as hex digits onto a multiplexed common-anode seven-segment display.
module serial_addsub_hex #(
   parameter int WIDTH   = 8,
   parameter int REFRESH = 1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       sw1,
   input  logic [WIDTH-1:0]       sw2,
   input  logic                   cin,
   input  logic                   sub,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       sum,
   output logic                   cout,
   output logic                   ovf,
   output logic [WIDTH/4-1:0]     digit_sel,
   output logic [6:0]             led
);

   localparam int NDIG = WIDTH / 4;
   localparam int CW   = $clog2(WIDTH);
   localparam int SW   = $clog2(REFRESH + 1);
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [NDIG-1:0] SEL_RST = ~(NDIG'(1));

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NDIG-1:0]   sel_q, sel_d;
   logic [6:0]        led_q, led_d;
   logic [3:0]        nib;
   logic              bit_s;
   logic              carry_nx;

   // Hex digit to active-low segment pattern, bit order g,f,e,d,c,b,a.
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'b1000000;
         4'h1: hex_glyph = 7'b1111001;
         4'h2: hex_glyph = 7'b0100100;
         4'h3: hex_glyph = 7'b0110000;
         4'h4: hex_glyph = 7'b0011001;
         4'h5: hex_glyph = 7'b0010010;
         4'h6: hex_glyph = 7'b0000010;
         4'h7: hex_glyph = 7'b1111000;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0011000;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b0000011;
         4'hC: hex_glyph = 7'b1000110;
         4'hD: hex_glyph = 7'b0100001;
         4'hE: hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   // One full-adder slice working on the current LSBs of the operand shifters.
   assign bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
   assign carry_nx = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

   // Sequencer: capture operands in IDLE, shift one bit per clock in RUN,
   // publish result/carry/overflow on the final bit, then a single DONE cycle.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = sw1;
               b_d     = sub ? ~sw2 : sw2;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = {bit_s, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = carry_nx;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {bit_s, res_q[WIDTH-1:1]};
               cout_d  = carry_nx;
               ovf_d   = carry_q ^ carry_nx;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Display scan: free-running dwell counter advances the digit index, and the
   // segment/enable registers follow the new index on that same edge.
   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SW'(REFRESH - 1)) begin
         scan_d = '0;
         idx_d  = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
      end
      nib   = '0;
      sel_d = '1;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_d == IW'(i)) begin
            nib      = sum_q[4*i +: 4];
            sel_d[i] = 1'b0;
         end
      end
      led_d = hex_glyph(nib);
   end

   // All state registers; reset returns the block to an idle, blank-zero display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         scan_q  <= '0;
         idx_q   <= '0;
         sel_q   <= SEL_RST;
         led_q   <= 7'b1000000;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         led_q   <= led_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign digit_sel = sel_q;
   assign led       = led_q;

endmodule

// File: tb/tb_serial_addsub_hex.sv
// Directed bench for serial_addsub_hex at WIDTH=8, REFRESH=4.
module tb_serial_addsub_hex;

   logic       clk;
   logic       rst_n;
   logic [7:0] sw1;
   logic [7:0] sw2;
   logic       cin;
   logic       sub;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;
   logic [1:0] digit_sel;
   logic [6:0] led;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       s;
      logic [7:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [8];

   serial_addsub_hex #(.WIDTH(8), .REFRESH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw1       (sw1),
      .sw2       (sw2),
      .cin       (cin),
      .sub       (sub),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .digit_sel (digit_sel),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation and tally the result.
   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and return at the following falling edge.
   task automatic tick();
      @(posedge clk);
      edge_n++;
      @(negedge clk);
   endtask

   // Pulse reset, verify the asynchronous reset values, and restart the edge count.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("rst_busy", {31'd0, busy}, 32'd0);
      check_output("rst_done", {31'd0, done}, 32'd0);
      check_output("rst_sum", {24'd0, sum}, 32'd0);
      check_output("rst_cout", {31'd0, cout}, 32'd0);
      check_output("rst_ovf", {31'd0, ovf}, 32'd0);
      check_output("rst_digit_sel", {30'd0, digit_sel}, 32'h2);
      check_output("rst_led", {25'd0, led}, 32'h40);
      @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      edge_n = 0;
   endtask

   // Run one operation: start pulse, scrambled switches afterwards, bounded wait
   // for done, then check busy length, latency and the held result.
   task automatic apply_stimulus(input vec_t v, input string tag);
      int busy_cnt;
      int lat;
      busy_cnt = 0;
      lat      = 0;
      sw1   = v.a;
      sw2   = v.b;
      cin   = v.c;
      sub   = v.s;
      start = 1'b1;
      tick();
      start = 1'b0;
      sw1   = ~v.a;
      sw2   = ~v.b;
      cin   = ~v.c;
      sub   = ~v.s;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      if (!done) begin
         errors++;
         checks++;
         $display("[TB] FAIL %s_timeout: got no done expected done within 20 cycles", tag);
      end else begin
         check_output({tag, "_latency"}, lat, 32'd8);
         check_output({tag, "_busy_cycles"}, busy_cnt, 32'd8);
         check_output({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
         check_output({tag, "_sum"}, {24'd0, sum}, {24'd0, v.exp_sum});
         check_output({tag, "_cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
         check_output({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
         tick();
         check_output({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      int done_cnt;
      int lat;
      vec_t v;
      rst_n = 1'b0;
      sw1   = '0;
      sw2   = '0;
      cin   = 1'b0;
      sub   = 1'b0;
      start = 1'b0;

      vecs[0] = '{8'h3A, 8'h45, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
      vecs[4] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[6] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[7] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

      $display("[TB] reset");
      do_reset();

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i], $sformatf("vec%0d", i));
      end

      $display("[TB] start ignored during RUN and DONE");
      sw1   = 8'h12;
      sw2   = 8'h34;
      cin   = 1'b0;
      sub   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      sw1   = 8'hFF;
      tick();
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      done_cnt = done ? 1 : 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) done_cnt++;
         tick();
      end
      check_output("ignore_done_count", done_cnt, 32'd1);
      check_output("ignore_sum", {24'd0, sum}, 32'h46);
      check_output("ignore_busy", {31'd0, busy}, 32'd0);
      sw1 = 8'hC3;
      sw2 = 8'h3C;
      for (int i = 0; i < 5; i++) tick();
      check_output("hold_sum", {24'd0, sum}, 32'h46);
      check_output("hold_cout", {31'd0, cout}, 32'd0);

      $display("[TB] reset during RUN");
      apply_stimulus(vecs[5], "pre_abort");
      sw1   = 8'h3A;
      sw2   = 8'h45;
      cin   = 1'b0;
      sub   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      check_output("abort_done", {31'd0, done}, 32'd0);
      check_output("abort_sum", {24'd0, sum}, 32'd0);
      check_output("abort_cout", {31'd0, cout}, 32'd0);
      check_output("abort_ovf", {31'd0, ovf}, 32'd0);
      check_output("abort_digit_sel", {30'd0, digit_sel}, 32'h2);
      check_output("abort_led", {25'd0, led}, 32'h40);
      tick();
      rst_n    = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) done_cnt++;
         tick();
      end
      check_output("abort_no_stale_activity", done_cnt, 32'd0);
      apply_stimulus(vecs[0], "post_abort");

      $display("[TB] display scan");
      do_reset();
      v = '{8'hA0, 8'h05, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
      apply_stimulus(v, "disp_op");
      while (edge_n < 16) tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         if (((edge_n / 4) % 2) == 1) begin
            check_output($sformatf("scan_sel_e%0d", edge_n), {30'd0, digit_sel}, 32'h1);
            check_output($sformatf("scan_led_e%0d", edge_n), {25'd0, led}, 32'h08);
         end else begin
            check_output($sformatf("scan_sel_e%0d", edge_n), {30'd0, digit_sel}, 32'h2);
            check_output($sformatf("scan_led_e%0d", edge_n), {25'd0, led}, 32'h12);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
